// File: rtl/dadda_pkg.sv
// Shared types and helpers for the 16x16 sequencer built around one 8x8 Dadda array.
package dadda_pkg;

    localparam int HALF_W = 8;
    localparam int FULL_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef logic [1:0] step_t;
    typedef logic [4:0] shift_t;

    localparam shift_t SH0  = 5'd0;
    localparam shift_t SH8  = 5'd8;
    localparam shift_t SH16 = 5'd16;

    // Cross terms (steps 1 and 2) both land at bit 8.
    function automatic shift_t stepShift(input step_t step);
        case (step)
            2'd0:    return SH0;
            2'd3:    return SH16;
            default: return SH8;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] stepHalf(input logic [FULL_W-1:0] op, input logic selHigh);
        return selHigh ? op[FULL_W-1:HALF_W] : op[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/dadda_tag_pipe.sv
// Delay line that carries each issued step's shift code alongside the multiplier latency.
module dadda_tag_pipe
    import dadda_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   valid_i,
    input  shift_t shift_i,
    output logic   valid_o,
    output shift_t shift_o
);

    generate
        if (DEPTH == 0) begin : gen_wire
            logic unusedClkRst;
            assign unusedClkRst = clk | rst;
            assign valid_o      = valid_i;
            assign shift_o      = shift_i;
        end else begin : gen_pipe
            logic   [DEPTH-1:0] valid_q;
            shift_t             shift_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    for (int i = 0; i < DEPTH; i++) shift_q[i] <= SH0;
                end else begin
                    valid_q[0] <= valid_i;
                    shift_q[0] <= shift_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        shift_q[i] <= shift_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[DEPTH-1];
            assign shift_o = shift_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dadda_mul16_seq.sv
// Unsigned 16x16->32 multiply by issuing four 8x8 partial products to a shared Dadda array.
module dadda_mul16_seq
    import dadda_pkg::*;
#(
    parameter int MUL_LAT = 0,
    parameter int HALF_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    output logic [HALF_W-1:0]   mul_a,
    output logic [HALF_W-1:0]   mul_b,
    output logic                mul_issue,
    input  logic [2*HALF_W-1:0] mul_p,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [4*HALF_W-1:0] res_p,
    output logic                busy
);

    state_t        state_q;
    step_t         step_q;
    logic [1:0]    drainCnt_q;
    logic [15:0]   aHold_q, bHold_q;
    logic [31:0]   acc_q, accNext, resP_q;
    logic [7:0]    mulA_q, mulB_q;
    logic          mulIssue_q, resValid_q, startReady_q, busy_q;
    logic          tagValid;
    shift_t        tagShift;
    step_t         stepNext;

    dadda_tag_pipe #(.DEPTH(MUL_LAT)) u_tagPipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (mulIssue_q),
        .shift_i (stepShift(step_q)),
        .valid_o (tagValid),
        .shift_o (tagShift)
    );

    // Products arrive tagged with their weight; fold them in as they emerge.
    always_comb begin
        accNext = acc_q;
        if (tagValid) accNext = acc_q + (32'(mul_p) << tagShift);
    end

    assign stepNext = step_t'(step_q + 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= 2'd0;
            drainCnt_q   <= 2'd0;
            aHold_q      <= '0;
            bHold_q      <= '0;
            acc_q        <= '0;
            resP_q       <= '0;
            mulA_q       <= '0;
            mulB_q       <= '0;
            mulIssue_q   <= 1'b0;
            resValid_q   <= 1'b0;
            startReady_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            acc_q <= accNext;
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        aHold_q      <= a;
                        bHold_q      <= b;
                        acc_q        <= '0;
                        step_q       <= 2'd0;
                        mulA_q       <= stepHalf(a, 1'b0);
                        mulB_q       <= stepHalf(b, 1'b0);
                        mulIssue_q   <= 1'b1;
                        startReady_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (step_q == 2'd3) begin
                        mulIssue_q <= 1'b0;
                        drainCnt_q <= 2'd0;
                        if (MUL_LAT == 0) begin
                            resP_q     <= accNext;
                            resValid_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        step_q <= stepNext;
                        mulA_q <= stepHalf(aHold_q, stepNext[1]);
                        mulB_q <= stepHalf(bHold_q, stepNext[0]);
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == 2'(MUL_LAT - 1)) begin
                        resP_q     <= accNext;
                        resValid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        drainCnt_q <= drainCnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        resValid_q   <= 1'b0;
                        startReady_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = startReady_q;
    assign mul_a       = mulA_q;
    assign mul_b       = mulB_q;
    assign mul_issue   = mulIssue_q;
    assign res_valid   = resValid_q;
    assign res_p       = resP_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Drives a combinational-array and a two-cycle-array instance in lockstep against plain a*b.
module tb_dadda_mul16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        startValid;
    logic        resReady;
    logic [15:0] a, b;

    logic        startReady0, mulIssue0, resValid0, busy0;
    logic [7:0]  mulA0, mulB0;
    logic [15:0] mulP0;
    logic [31:0] resP0;

    logic        startReady2, mulIssue2, resValid2, busy2;
    logic [7:0]  mulA2, mulB2;
    logic [15:0] mulP2, pipe2a, pipe2b;
    logic [31:0] resP2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External 8x8 array models: one combinational, one with two register stages.
    assign mulP0 = 16'(mulA0) * 16'(mulB0);
    always @(posedge clk) begin
        pipe2a <= 16'(mulA2) * 16'(mulB2);
        pipe2b <= pipe2a;
    end
    assign mulP2 = pipe2b;

    dadda_mul16_seq #(.MUL_LAT(0), .HALF_W(8)) dut0 (
        .clk(clk), .rst(rst), .start_valid(startValid), .start_ready(startReady0),
        .a(a), .b(b), .mul_a(mulA0), .mul_b(mulB0), .mul_issue(mulIssue0), .mul_p(mulP0),
        .res_valid(resValid0), .res_ready(resReady), .res_p(resP0), .busy(busy0)
    );

    dadda_mul16_seq #(.MUL_LAT(2), .HALF_W(8)) dut2 (
        .clk(clk), .rst(rst), .start_valid(startValid), .start_ready(startReady2),
        .a(a), .b(b), .mul_a(mulA2), .mul_b(mulB2), .mul_issue(mulIssue2), .mul_p(mulP2),
        .res_valid(resValid2), .res_ready(resReady), .res_p(resP2), .busy(busy2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, observe issue/latency, optional back-pressure, release.
    task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                                 input bit scramble, input int holdCycles);
        int          lat0 = -1;
        int          lat2 = -1;
        int          n0 = 0;
        int          n2 = 0;
        logic [15:0] ops0 [8];
        logic [15:0] ops2 [8];
        logic [15:0] expOps [4];
        logic [31:0] expP;
        logic [31:0] held0, held2;

        expP   = 32'(opA) * 32'(opB);
        expOps = '{{opA[7:0], opB[7:0]}, {opA[7:0], opB[15:8]},
                   {opA[15:8], opB[7:0]}, {opA[15:8], opB[15:8]}};

        checkOutput("startReady idle", {30'd0, startReady0, startReady2}, 32'd3);
        a = opA; b = opB; startValid = 1'b1; resReady = 1'b0;
        @(negedge clk);
        startValid = 1'b0;
        checkOutput("busy after accept", {30'd0, busy0, busy2}, 32'd3);

        for (int k = 1; k <= 40; k++) begin
            if (mulIssue0) begin
                if (n0 < 8) ops0[n0] = {mulA0, mulB0};
                n0++;
            end
            if (mulIssue2) begin
                if (n2 < 8) ops2[n2] = {mulA2, mulB2};
                n2++;
            end
            if (resValid0 && lat0 < 0) lat0 = k;
            if (resValid2 && lat2 < 0) lat2 = k;
            if (lat0 >= 0 && lat2 >= 0) break;
            if (scramble) begin
                a = 16'($urandom);
                b = 16'($urandom);
                startValid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        startValid = 1'b0;

        checkOutput("latency lat0", 32'(lat0), 32'd5);
        checkOutput("latency lat2", 32'(lat2), 32'd7);
        checkOutput("issue count lat0", 32'(n0), 32'd4);
        checkOutput("issue count lat2", 32'(n2), 32'd4);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("ops lat0 step%0d", s), 32'(ops0[s]), 32'(expOps[s]));
            checkOutput($sformatf("ops lat2 step%0d", s), 32'(ops2[s]), 32'(expOps[s]));
        end
        checkOutput("res_p lat0", resP0, expP);
        checkOutput("res_p lat2", resP2, expP);

        held0 = resP0;
        held2 = resP2;
        repeat (holdCycles) begin
            @(negedge clk);
            checkOutput("hold res_valid", {30'd0, resValid0, resValid2}, 32'd3);
            checkOutput("hold start_ready", {30'd0, startReady0, startReady2}, 32'd0);
            checkOutput("hold res_p lat0", resP0, held0);
            checkOutput("hold res_p lat2", resP2, held2);
        end

        resReady = 1'b1;
        @(negedge clk);
        resReady = 1'b0;
        checkOutput("released res_valid", {30'd0, resValid0, resValid2}, 32'd0);
        checkOutput("released start_ready", {30'd0, startReady0, startReady2}, 32'd3);
    endtask

    initial begin
        rst = 1'b1; startValid = 1'b0; resReady = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset start_ready", {30'd0, startReady0, startReady2}, 32'd3);
        checkOutput("reset res_valid", {30'd0, resValid0, resValid2}, 32'd0);
        checkOutput("reset res_p", resP0 | resP2, 32'd0);
        checkOutput("reset mul_issue", {30'd0, mulIssue0, mulIssue2}, 32'd0);
        checkOutput("reset mul ops", {mulA0, mulB0, mulA2, mulB2}, 32'd0);
        checkOutput("reset busy", {30'd0, busy0, busy2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h5678, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 0);
        applyStimulus(16'h0000, 16'hBEEF, 1'b0, 0);
        applyStimulus(16'h0001, 16'hBEEF, 1'b0, 0);
        applyStimulus(16'hA5C3, 16'h3C5A, 1'b0, 10);

        // Abort a transaction at step 2 and make sure nothing of it survives.
        a = 16'h00FF; b = 16'h0100; startValid = 1'b1;
        @(negedge clk);
        startValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset res_valid", {30'd0, resValid0, resValid2}, 32'd0);
        checkOutput("midreset start_ready", {30'd0, startReady0, startReady2}, 32'd3);
        checkOutput("midreset busy", {30'd0, busy0, busy2}, 32'd0);
        checkOutput("midreset mul_issue", {30'd0, mulIssue0, mulIssue2}, 32'd0);
        applyStimulus(16'h0003, 16'h0005, 1'b0, 0);

        applyStimulus(16'hCAFE, 16'hF00D, 1'b1, 2);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dadda_mul16_seq.md
Name: dadda_mul16_seq

Overview:
Sequencer that computes an unsigned 16x16 -> 32-bit product by time-sharing one external 8x8 Dadda multiplier across four partial-product steps.
- Accepts operands on a valid/ready handshake, issues the four 8x8 operand pairs, shifts and accumulates the returned products, and holds the 32-bit result on a valid/ready output.
- Sits between the arithmetic issue logic and the shared 8x8 Dadda array instance.

Parameters:
- MUL_LAT, 0, cycles from mul_a/mul_b driven to mul_p valid; legal range 0..2 (0 = combinational array).
- HALF_W, 8, width of the shared multiplier operand; fixed at 8, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operand pair a/b offered.
- start_ready  output  1  block can accept operands.
- a  input  16  multiplicand, unsigned.
- b  input  16  multiplier, unsigned.
- mul_a  output  8  operand A to the shared 8x8 multiplier.
- mul_b  output  8  operand B to the shared 8x8 multiplier.
- mul_issue  output  1  high on cycles where mul_a/mul_b carry a live step.
- mul_p  input  16  product from the shared multiplier, valid MUL_LAT cycles after issue.
- res_valid  output  1  res_p holds the final product.
- res_ready  input  1  consumer accepts res_p.
- res_p  output  32  product a*b.
- busy  output  1  high in ISSUE or DRAIN.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: start_ready=1, res_valid=0, res_p=0, mul_issue=0, mul_a=0, mul_b=0, busy=0. Reset also clears the accumulator, step counter and tag pipe.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - start_ready=1.
  - On start_valid&start_ready: latch a, b; clear the accumulator; step=0; go to ISSUE.
- ISSUE
  - Exactly 4 consecutive cycles, step 0..3; mul_issue=1 on each.
  - Operand pairs: step0 = a[7:0] x b[7:0], shift 0; step1 = a[7:0] x b[15:8], shift 8; step2 = a[15:8] x b[7:0], shift 8; step3 = a[15:8] x b[15:8], shift 16.
  - After step3: go to DRAIN if MUL_LAT>0, else DONE.
- DRAIN
  - Lasts MUL_LAT cycles; mul_issue=0; mul_a/mul_b hold their last values.
  - Then go to DONE.
- Accumulation
  - Each issued step pushes its shift code into a MUL_LAT-deep tag pipe.
  - When a tag emerges, acc <= acc + (mul_p << shift), computed 32 bits wide.
  - The sum never exceeds 0xFFFE0001, so acc needs no overflow handling.
  - With MUL_LAT=0, mul_p is added in the same cycle as its issue.
- DONE
  - res_valid=1 and res_p=acc.
  - res_p is stable while res_valid&!res_ready.
  - On res_ready: res_valid<=0 and go to IDLE.
  - start_ready is 0 in DONE; no overlap with a new operand pair.
- Latency: accept at cycle T gives res_valid at T+5+MUL_LAT.
- Input stability: a and b are sampled only at the accept edge; later changes are ignored.
- Back-pressure: res_ready held low keeps the block in DONE indefinitely, with no output change.
- start_valid outside IDLE is ignored; no operand is lost because start_ready=0.
- Reset mid-operation: on any cycle, the next state is IDLE with all reset values. A partially accumulated product is discarded and no res_valid pulse occurs.
- mul_a/mul_b in IDLE/DONE: hold their last values, to avoid toggling the array.

Decomposition:
- Package dadda_pkg holds:
  - HALF_W=8 and FULL_W=16;
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - 2-bit step type;
  - shift-code constants SH0=0, SH8=8, SH16=16;
  - a function mapping step to shift.
- Sub-module dadda_tag_pipe: parameterised MUL_LAT-deep shift register carrying {valid, shift code}, with a synchronous rst that clears all valid bits. At depth 0 it degenerates to wires.

Test Plan:
- MUL_LAT=0: a=0x1234, b=0x5678, res_ready=1 -> res_valid at T+5, res_p=0x06260060; mul_issue high exactly 4 cycles.
- MUL_LAT=2: a=0xFFFF, b=0xFFFF -> res_p=0xFFFE0001 at T+7. Check mul_a/mul_b sequence FF/FF x4 and the final product.
- Zero and identity: a=0x0000, b=0xBEEF -> 0x00000000; then a=0x0001, b=0xBEEF -> 0x0000BEEF, issued back-to-back after each result is consumed.
- Back-pressure: res_ready low 10 cycles after res_valid -> res_p stable, start_ready=0 throughout. The accept cycle after res_ready rises returns to IDLE, then a new operand pair is accepted.
- Reset mid-op: rst at step 2 with a=0x00FF, b=0x0100 -> next cycle state IDLE, res_valid=0, start_ready=1. A subsequent 0x0003 x 0x0005 gives 0x0000000F, with no stale accumulation.
- Operand change: a/b altered every cycle after accept -> result equals the product of the values sampled at accept.
